// File: rtl/wb_thread_ctrl.sv
// rtl/wb_thread_ctrl.sv - write-back stage with per-thread sleep/wake/kill control
//
// Purpose: formats and issues the register-file write for the instruction in
// WB, and runs the per-thread IDLE/RUN/SLEEP state machines that drive the
// fetch scheduler's run mask.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid_wb, tid_wb      WB occupancy and issuing thread
//   trd_ctrl_wb           thread op (00 none, 01 sleep, 10 wake, 11 kill)
//   target_tid_wb         wake target
//   wb_sel_wb             1 = load data, 0 = execute data
//   exe_data_wb           execute result
//   d_rd_data             raw data-memory word
//   ld_size_wb            00 byte, 01 half, 1x word
//   ld_uns_wb             zero-extend load
//   byte_off_wb           load address bits [1:0]
//   rd_wr_en_wb           instruction writes rd
//   rd_addr_wb            destination register
//   rf_wr_en/tid/addr     register-file write port
//   wb_data_wb            formatted write data
//   run_mask, sleep_mask  per-thread RUN / SLEEP flags (registered)
//   all_dead              every thread IDLE (sticky until reset)
//   sleep, wake, kill     one-hot pulses for an accepted thread op
module wb_thread_ctrl #(
  parameter int NUM_THREAD = 4,
  parameter int TID_W      = $clog2(NUM_THREAD),
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_wb,
  input  logic [TID_W-1:0]      tid_wb,
  input  logic [1:0]            trd_ctrl_wb,
  input  logic [TID_W-1:0]      target_tid_wb,
  input  logic                  wb_sel_wb,
  input  logic [XLEN-1:0]       exe_data_wb,
  input  logic [XLEN-1:0]       d_rd_data,
  input  logic [1:0]            ld_size_wb,
  input  logic                  ld_uns_wb,
  input  logic [1:0]            byte_off_wb,
  input  logic                  rd_wr_en_wb,
  input  logic [4:0]            rd_addr_wb,
  output logic                  rf_wr_en,
  output logic [TID_W-1:0]      rf_wr_tid,
  output logic [4:0]            rf_wr_addr,
  output logic [XLEN-1:0]       wb_data_wb,
  output logic [NUM_THREAD-1:0] run_mask,
  output logic [NUM_THREAD-1:0] sleep_mask,
  output logic                  all_dead,
  output logic                  sleep,
  output logic                  wake,
  output logic                  kill
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SLEEP = 2'd2
  } thr_state_e;

  thr_state_e            r_state     [NUM_THREAD];
  thr_state_e            w_state_nxt [NUM_THREAD];
  logic [NUM_THREAD-1:0] r_pw;
  logic [NUM_THREAD-1:0] w_pw_nxt;
  logic                  r_all_dead;
  logic                  w_all_dead_nxt;
  logic                  w_none_alive;

  logic                  w_tid_ok;
  logic                  w_tgt_ok;
  logic                  w_acc;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [XLEN-1:0]       w_ld_data;

  // Guards keep out-of-range IDs harmless when NUM_THREAD is not a power of 2.
  assign w_tid_ok = (int'(tid_wb) < NUM_THREAD);
  assign w_tgt_ok = (int'(target_tid_wb) < NUM_THREAD);
  assign w_acc    = valid_wb && w_tid_ok && (r_state[tid_wb] == ST_RUN);

  assign sleep = w_acc && (trd_ctrl_wb == 2'b01);
  assign wake  = w_acc && (trd_ctrl_wb == 2'b10);
  assign kill  = w_acc && (trd_ctrl_wb == 2'b11);

  assign rf_wr_en   = w_acc && rd_wr_en_wb && (rd_addr_wb != 5'd0);
  assign rf_wr_tid  = tid_wb;
  assign rf_wr_addr = rd_addr_wb;

  always_comb begin
    w_byte = 8'h00;
    case (byte_off_wb)
      2'd0:    w_byte = d_rd_data[7:0];
      2'd1:    w_byte = d_rd_data[15:8];
      2'd2:    w_byte = d_rd_data[23:16];
      default: w_byte = d_rd_data[31:24];
    endcase
    // Halfword select uses only the upper offset bit; misaligned halves are not split.
    w_half = byte_off_wb[1] ? d_rd_data[31:16] : d_rd_data[15:0];
    case (ld_size_wb)
      2'b00:   w_ld_data = {{(XLEN-8){~ld_uns_wb & w_byte[7]}}, w_byte};
      2'b01:   w_ld_data = {{(XLEN-16){~ld_uns_wb & w_half[15]}}, w_half};
      default: w_ld_data = d_rd_data;
    endcase
  end

  assign wb_data_wb = wb_sel_wb ? w_ld_data : exe_data_wb;

  always_comb begin
    for (int t = 0; t < NUM_THREAD; t++) begin
      w_state_nxt[t] = r_state[t];
    end
    w_pw_nxt = r_pw;
    if (w_acc) begin
      case (trd_ctrl_wb)
        2'b01: begin
          // A wake that arrived while running is consumed here instead of sleeping.
          if (r_pw[tid_wb]) w_pw_nxt[tid_wb] = 1'b0;
          else              w_state_nxt[tid_wb] = ST_SLEEP;
        end
        2'b10: begin
          if (w_tgt_ok) begin
            case (r_state[target_tid_wb])
              ST_SLEEP: w_state_nxt[target_tid_wb] = ST_RUN;
              ST_IDLE: begin
                w_state_nxt[target_tid_wb] = ST_RUN;
                w_pw_nxt[target_tid_wb]    = 1'b0;
              end
              ST_RUN:   w_pw_nxt[target_tid_wb] = 1'b1;
              default:  ;
            endcase
          end
        end
        2'b11: begin
          w_state_nxt[tid_wb] = ST_IDLE;
          w_pw_nxt[tid_wb]    = 1'b0;
        end
        default: ;
      endcase
    end
    w_none_alive = 1'b1;
    for (int t = 0; t < NUM_THREAD; t++) begin
      if (w_state_nxt[t] != ST_IDLE) w_none_alive = 1'b0;
    end
    w_all_dead_nxt = r_all_dead | (kill & w_none_alive);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_THREAD; t++) begin
        r_state[t] <= (t == 0) ? ST_RUN : ST_IDLE;
      end
      r_pw       <= '0;
      r_all_dead <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_THREAD; t++) begin
        r_state[t] <= w_state_nxt[t];
      end
      r_pw       <= w_pw_nxt;
      r_all_dead <= w_all_dead_nxt;
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_THREAD; t++) begin
      run_mask[t]   = (r_state[t] == ST_RUN);
      sleep_mask[t] = (r_state[t] == ST_SLEEP);
    end
  end

  assign all_dead = r_all_dead;

endmodule

// File: tb/tb_wb_thread_ctrl.sv
// tb/tb_wb_thread_ctrl.sv - directed self-checking bench for wb_thread_ctrl
module tb_wb_thread_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid_wb;
  logic [1:0]  tid_wb;
  logic [1:0]  trd_ctrl_wb;
  logic [1:0]  target_tid_wb;
  logic        wb_sel_wb;
  logic [31:0] exe_data_wb;
  logic [31:0] d_rd_data;
  logic [1:0]  ld_size_wb;
  logic        ld_uns_wb;
  logic [1:0]  byte_off_wb;
  logic        rd_wr_en_wb;
  logic [4:0]  rd_addr_wb;
  logic        rf_wr_en;
  logic [1:0]  rf_wr_tid;
  logic [4:0]  rf_wr_addr;
  logic [31:0] wb_data_wb;
  logic [3:0]  run_mask;
  logic [3:0]  sleep_mask;
  logic        all_dead;
  logic        sleep;
  logic        wake;
  logic        kill;

  int n_cmp = 0;
  int n_err = 0;

  wb_thread_ctrl #(.NUM_THREAD(4), .TID_W(2), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_wb(valid_wb), .tid_wb(tid_wb),
    .trd_ctrl_wb(trd_ctrl_wb), .target_tid_wb(target_tid_wb),
    .wb_sel_wb(wb_sel_wb), .exe_data_wb(exe_data_wb), .d_rd_data(d_rd_data),
    .ld_size_wb(ld_size_wb), .ld_uns_wb(ld_uns_wb), .byte_off_wb(byte_off_wb),
    .rd_wr_en_wb(rd_wr_en_wb), .rd_addr_wb(rd_addr_wb),
    .rf_wr_en(rf_wr_en), .rf_wr_tid(rf_wr_tid), .rf_wr_addr(rf_wr_addr),
    .wb_data_wb(wb_data_wb), .run_mask(run_mask), .sleep_mask(sleep_mask),
    .all_dead(all_dead), .sleep(sleep), .wake(wake), .kill(kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] tid, input logic [1:0] ctl, input logic [1:0] tgt);
    valid_wb      = 1'b1;
    tid_wb        = tid;
    trd_ctrl_wb   = ctl;
    target_tid_wb = tgt;
    rd_wr_en_wb   = 1'b0;
    rd_addr_wb    = 5'd0;
    #1;
  endtask

  task automatic idle_in();
    valid_wb    = 1'b0;
    trd_ctrl_wb = 2'b00;
    rd_wr_en_wb = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    step();
    n_cmp++; if (run_mask !== 4'b0001) begin n_err++; $display("FAIL rst_run_mask: got %b expected %b", run_mask, 4'b0001); end
    n_cmp++; if (sleep_mask !== 4'b0000) begin n_err++; $display("FAIL rst_sleep_mask: got %b expected %b", sleep_mask, 4'b0000); end
    n_cmp++; if (all_dead !== 1'b0) begin n_err++; $display("FAIL rst_all_dead: got %b expected 0", all_dead); end
    rst_n = 1'b1;
    op(2'd1, 2'b00, 2'd0);
    rd_wr_en_wb = 1'b1; rd_addr_wb = 5'd7; #1;
    n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_idle_write: got %b expected 0", rf_wr_en); end
    op(2'd0, 2'b00, 2'd0);
    rd_wr_en_wb = 1'b1; rd_addr_wb = 5'd5; #1;
    n_cmp++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL t0_write_en: got %b expected 1", rf_wr_en); end
    n_cmp++; if (rf_wr_addr !== 5'd5 || rf_wr_tid !== 2'd0) begin n_err++; $display("FAIL t0_write_addr: got %0d/%0d expected 5/0", rf_wr_addr, rf_wr_tid); end
    idle_in();
  endtask

  task automatic test_load_format();
    op(2'd0, 2'b00, 2'd0);
    d_rd_data = 32'h8081_F2F3; exe_data_wb = 32'h1234_5678; wb_sel_wb = 1'b1;
    rd_wr_en_wb = 1'b1; rd_addr_wb = 5'd3;
    ld_size_wb = 2'b00; byte_off_wb = 2'd1; ld_uns_wb = 1'b0; #1;
    n_cmp++; if (wb_data_wb !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL lb_off1: got %h expected %h", wb_data_wb, 32'hFFFF_FFF2); end
    ld_uns_wb = 1'b1; #1;
    n_cmp++; if (wb_data_wb !== 32'h0000_00F2) begin n_err++; $display("FAIL lbu_off1: got %h expected %h", wb_data_wb, 32'h0000_00F2); end
    ld_size_wb = 2'b00; byte_off_wb = 2'd3; ld_uns_wb = 1'b0; #1;
    n_cmp++; if (wb_data_wb !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_off3: got %h expected %h", wb_data_wb, 32'hFFFF_FF80); end
    ld_size_wb = 2'b01; byte_off_wb = 2'd2; ld_uns_wb = 1'b0; #1;
    n_cmp++; if (wb_data_wb !== 32'hFFFF_8081) begin n_err++; $display("FAIL lh_off2: got %h expected %h", wb_data_wb, 32'hFFFF_8081); end
    byte_off_wb = 2'd1; ld_uns_wb = 1'b1; #1;
    n_cmp++; if (wb_data_wb !== 32'h0000_F2F3) begin n_err++; $display("FAIL lhu_off1: got %h expected %h", wb_data_wb, 32'h0000_F2F3); end
    ld_size_wb = 2'b10; byte_off_wb = 2'd0; #1;
    n_cmp++; if (wb_data_wb !== 32'h8081_F2F3) begin n_err++; $display("FAIL lw: got %h expected %h", wb_data_wb, 32'h8081_F2F3); end
    ld_size_wb = 2'b11; #1;
    n_cmp++; if (wb_data_wb !== 32'h8081_F2F3) begin n_err++; $display("FAIL ld_size11: got %h expected %h", wb_data_wb, 32'h8081_F2F3); end
    wb_sel_wb = 1'b0; #1;
    n_cmp++; if (wb_data_wb !== 32'h1234_5678) begin n_err++; $display("FAIL exe_sel: got %h expected %h", wb_data_wb, 32'h1234_5678); end
    rd_addr_wb = 5'd0; #1;
    n_cmp++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL rd_zero: got %b expected 0", rf_wr_en); end
    idle_in();
  endtask

  task automatic test_spawn_sleep_wake();
    op(2'd0, 2'b10, 2'd2);
    n_cmp++; if (wake !== 1'b1 || sleep !== 1'b0 || kill !== 1'b0) begin n_err++; $display("FAIL wake_pulse: got %b%b%b expected 010", sleep, wake, kill); end
    step();
    n_cmp++; if (run_mask !== 4'b0101) begin n_err++; $display("FAIL spawn_run: got %b expected %b", run_mask, 4'b0101); end
    op(2'd2, 2'b01, 2'd0);
    n_cmp++; if (sleep !== 1'b1) begin n_err++; $display("FAIL sleep_pulse: got %b expected 1", sleep); end
    step();
    n_cmp++; if (run_mask !== 4'b0001 || sleep_mask !== 4'b0100) begin n_err++; $display("FAIL sleep_masks: got %b/%b expected 0001/0100", run_mask, sleep_mask); end
    op(2'd2, 2'b01, 2'd0);
    n_cmp++; if (sleep !== 1'b0) begin n_err++; $display("FAIL sleeping_squash: got %b expected 0", sleep); end
    op(2'd0, 2'b10, 2'd2);
    step();
    n_cmp++; if (run_mask !== 4'b0101 || sleep_mask !== 4'b0000) begin n_err++; $display("FAIL rewake: got %b/%b expected 0101/0000", run_mask, sleep_mask); end
  endtask

  task automatic test_lost_wakeup();
    op(2'd0, 2'b10, 2'd1);
    step();
    op(2'd0, 2'b10, 2'd1);
    step();
    n_cmp++; if (run_mask !== 4'b0111) begin n_err++; $display("FAIL lw_run: got %b expected %b", run_mask, 4'b0111); end
    op(2'd1, 2'b01, 2'd0);
    n_cmp++; if (sleep !== 1'b1) begin n_err++; $display("FAIL lw_sleep_pulse: got %b expected 1", sleep); end
    step();
    n_cmp++; if (run_mask !== 4'b0111 || sleep_mask !== 4'b0000) begin n_err++; $display("FAIL lw_consumed: got %b/%b expected 0111/0000", run_mask, sleep_mask); end
    op(2'd1, 2'b01, 2'd0);
    step();
    n_cmp++; if (sleep_mask !== 4'b0010 || run_mask !== 4'b0101) begin n_err++; $display("FAIL lw_second_sleep: got %b/%b expected 0101/0010", run_mask, sleep_mask); end
  endtask

  task automatic test_kill_all_dead();
    op(2'd2, 2'b11, 2'd0);
    n_cmp++; if (kill !== 1'b1 || wake !== 1'b0) begin n_err++; $display("FAIL kill_pulse: got %b%b expected 10", kill, wake); end
    step();
    n_cmp++; if (run_mask !== 4'b0001 || all_dead !== 1'b0) begin n_err++; $display("FAIL kill_t2: got %b/%b expected 0001/0", run_mask, all_dead); end
    op(2'd0, 2'b10, 2'd1);
    step();
    op(2'd0, 2'b11, 2'd0);
    step();
    n_cmp++; if (run_mask !== 4'b0010 || all_dead !== 1'b0) begin n_err++; $display("FAIL kill_t0: got %b/%b expected 0010/0", run_mask, all_dead); end
    op(2'd1, 2'b11, 2'd0);
    step();
    n_cmp++; if (run_mask !== 4'b0000 || sleep_mask !== 4'b0000 || all_dead !== 1'b1) begin n_err++; $display("FAIL all_dead: got %b/%b/%b expected 0000/0000/1", run_mask, sleep_mask, all_dead); end
    op(2'd0, 2'b10, 2'd2);
    rd_wr_en_wb = 1'b1; rd_addr_wb = 5'd9; #1;
    n_cmp++; if (wake !== 1'b0 || rf_wr_en !== 1'b0) begin n_err++; $display("FAIL dead_squash: got %b/%b expected 0/0", wake, rf_wr_en); end
    step();
    n_cmp++; if (run_mask !== 4'b0000 || all_dead !== 1'b1) begin n_err++; $display("FAIL dead_hold: got %b/%b expected 0000/1", run_mask, all_dead); end
    idle_in();
  endtask

  task automatic test_squash_async_reset();
    rst_n = 1'b0;
    op(2'd0, 2'b10, 2'd3);
    n_cmp++; if (wake !== 1'b1) begin n_err++; $display("FAIL wake_in_reset: got %b expected 1", wake); end
    step();
    rst_n = 1'b1;
    #1;
    step();
    n_cmp++; if (run_mask !== 4'b1001) begin n_err++; $display("FAIL op_at_release: got %b expected %b", run_mask, 4'b1001); end
    op(2'd0, 2'b10, 2'd1);
    step();
    op(2'd0, 2'b10, 2'd2);
    step();
    op(2'd0, 2'b11, 2'd0);
    step();
    n_cmp++; if (run_mask !== 4'b1110) begin n_err++; $display("FAIL pre_reset_run: got %b expected %b", run_mask, 4'b1110); end
    op(2'd0, 2'b10, 2'd0);
    rd_wr_en_wb = 1'b1; rd_addr_wb = 5'd4; #1;
    n_cmp++; if (wake !== 1'b0 || sleep !== 1'b0 || kill !== 1'b0 || rf_wr_en !== 1'b0) begin n_err++; $display("FAIL idle_squash: got %b%b%b/%b expected 000/0", sleep, wake, kill, rf_wr_en); end
    step();
    n_cmp++; if (run_mask !== 4'b1110) begin n_err++; $display("FAIL idle_no_change: got %b expected %b", run_mask, 4'b1110); end
    idle_in();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (run_mask !== 4'b0001 || sleep_mask !== 4'b0000 || all_dead !== 1'b0) begin n_err++; $display("FAIL async_reset: got %b/%b/%b expected 0001/0000/0", run_mask, sleep_mask, all_dead); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; valid_wb = 1'b0; tid_wb = '0; trd_ctrl_wb = '0; target_tid_wb = '0;
    wb_sel_wb = 1'b0; exe_data_wb = '0; d_rd_data = '0; ld_size_wb = '0;
    ld_uns_wb = 1'b0; byte_off_wb = '0; rd_wr_en_wb = 1'b0; rd_addr_wb = '0;
    test_reset();
    test_load_format();
    test_spawn_sleep_wake();
    test_lost_wakeup();
    test_kill_all_dead();
    test_squash_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
